// File: rtl/dmem_access_pkg.sv
// Shared types and helpers for the memory-stage data-bus master.
// Contents: bus widths, access-size encoding, FSM state encoding, and the dbus
// request/response records. Also holds the size-to-byte-mask helper.
package dmem_access_pkg;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
      msize_t        size;
      logic [SW-1:0] strobe;
      logic [DW-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic          addr_ok;
      logic          data_ok;
      logic [DW-1:0] data;
   } dbus_resp_t;

   // The mask is LSB-justified; the caller shifts it into its byte lane.
   function automatic logic [SW-1:0] size_mask(input msize_t size);
      logic [SW-1:0] mask;
      unique case (size)
         MSIZE1:  mask = 8'h01;
         MSIZE2:  mask = 8'h03;
         MSIZE4:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/dmem_strobe_gen.sv
// Combinational lane formatter for one memory access.
// Ports:
//   i_msize    access size
//   i_addr_lo  byte offset within the 64-bit bus word
//   i_write    store (enables the byte strobe)
//   i_wdata    LSB-justified store data
//   o_strobe   byte enables, zero for loads
//   o_data     store data shifted into its byte lane
//   o_misalign offset not a multiple of the access size (ungated)
module dmem_strobe_gen
   import dmem_access_pkg::*;
(
   input  msize_t        i_msize,
   input  logic [2:0]    i_addr_lo,
   input  logic          i_write,
   input  logic [DW-1:0] i_wdata,
   output logic [SW-1:0] o_strobe,
   output logic [DW-1:0] o_data,
   output logic          o_misalign
);

   logic [SW-1:0] w_mask;

   always_comb begin
      w_mask   = size_mask(i_msize);
      // Shifting within 8 bits drops enables that would fall past byte 7;
      // that only happens for misaligned accesses, which never reach the bus.
      o_strobe = i_write ? (w_mask << i_addr_lo) : '0;
      o_data   = i_wdata << {i_addr_lo, 3'b000};
      unique case (i_msize)
         MSIZE1:  o_misalign = 1'b0;
         MSIZE2:  o_misalign = i_addr_lo[0];
         MSIZE4:  o_misalign = |i_addr_lo[1:0];
         default: o_misalign = |i_addr_lo;
      endcase
   end

endmodule

// File: rtl/dmem_access.sv
// Memory-stage data-bus master. Issues one dbus transaction per load/store,
// stalls the pipeline until the response arrives and presents the raw read
// word plus its byte offset to the downstream load-extension logic.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   op_*                  memory-stage operation (valid/read/write/addr/wdata/msize)
//   advance, flush        pipeline advance and kill for the memory stage
//   dreq_*                bus request (valid/addr/size/strobe/data)
//   dresp_*               bus response (addr_ok/data_ok/data)
//   raw_data, raw_addr    captured read word and op_addr[2:0]
//   mem_stall, misalign   pipeline hold, misaligned-access flag
//
// state | meaning
// IDLE  | no access in flight; a legal, unflushed op starts one
// REQ   | request on the bus, fields frozen until data_ok
// DONE  | response captured, waiting for the pipeline to advance
module dmem_access
   import dmem_access_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          op_valid,
   input  logic          op_read,
   input  logic          op_write,
   input  logic [AW-1:0] op_addr,
   input  logic [DW-1:0] op_wdata,
   input  msize_t        op_msize,
   input  logic          advance,
   input  logic          flush,
   output logic          dreq_valid,
   output logic [AW-1:0] dreq_addr,
   output msize_t        dreq_size,
   output logic [SW-1:0] dreq_strobe,
   output logic [DW-1:0] dreq_data,
   input  logic          dresp_addr_ok,
   input  logic          dresp_data_ok,
   input  logic [DW-1:0] dresp_data,
   output logic [DW-1:0] raw_data,
   output logic [2:0]    raw_addr,
   output logic          mem_stall,
   output logic          misalign
);

   dmem_state_t   r_state;
   dmem_state_t   w_state_nxt;
   dbus_req_t     r_req;
   logic          r_kill;
   logic [DW-1:0] r_raw_data;
   logic [2:0]    r_raw_addr;

   logic [SW-1:0] w_strobe;
   logic [DW-1:0] w_data;
   logic          w_misalign_raw;
   logic          w_mem_op;
   logic          w_start;
   logic          w_capture;
   logic          w_unused_addr_ok;

   // Address acceptance carries no control meaning here: completion is
   // signalled by data_ok alone.
   assign w_unused_addr_ok = dresp_addr_ok;

   dmem_strobe_gen u_strobe_gen (
      .i_msize    (op_msize),
      .i_addr_lo  (op_addr[2:0]),
      .i_write    (op_write),
      .i_wdata    (op_wdata),
      .o_strobe   (w_strobe),
      .o_data     (w_data),
      .o_misalign (w_misalign_raw)
   );

   assign w_mem_op = op_valid & (op_read | op_write);
   assign misalign = w_mem_op & w_misalign_raw;
   assign w_start  = w_mem_op & ~w_misalign_raw & ~flush;

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      mem_stall   = 1'b0;
      unique case (r_state)
         IDLE: begin
            mem_stall = w_start;
            if (w_start) w_state_nxt = REQ;
         end
         REQ: begin
            mem_stall = 1'b1;
            if (dresp_data_ok) begin
               // A flush coinciding with completion kills the op as well.
               if (r_kill || flush) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DONE;
                  w_capture   = 1'b1;
               end
            end
         end
         DONE: begin
            if (advance || flush) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_req      <= '0;
         r_kill     <= 1'b0;
         r_raw_data <= '0;
         r_raw_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_req.valid <= (w_state_nxt == REQ);
         // Freeze the request fields at start so the bus sees them stable
         // for the whole transaction regardless of upstream activity.
         if (r_state == IDLE && w_start) begin
            r_req.addr   <= op_addr;
            r_req.size   <= op_msize;
            r_req.strobe <= w_strobe;
            r_req.data   <= w_data;
         end
         r_kill <= (r_state == REQ) & ~dresp_data_ok & (r_kill | flush);
         if (w_capture) begin
            r_raw_data <= dresp_data;
            r_raw_addr <= r_req.addr[2:0];
         end
      end
   end

   // Outside REQ the request fields show the current op's formatting; they
   // carry no meaning while dreq_valid is low.
   always_comb begin
      dreq_valid = r_req.valid;
      if (r_state == REQ) begin
         dreq_addr   = r_req.addr;
         dreq_size   = r_req.size;
         dreq_strobe = r_req.strobe;
         dreq_data   = r_req.data;
      end else begin
         dreq_addr   = op_addr;
         dreq_size   = op_msize;
         dreq_strobe = w_strobe;
         dreq_data   = w_data;
      end
   end

   assign raw_data = r_raw_data;
   assign raw_addr = r_raw_addr;

endmodule

// File: tb/tb_dmem_access.sv
module tb_dmem_access;
   import dmem_access_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid, op_read, op_write;
   logic [63:0] op_addr, op_wdata;
   msize_t      op_msize;
   logic        advance, flush;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   msize_t      dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok, dresp_data_ok;
   logic [63:0] dresp_data;
   logic [63:0] raw_data;
   logic [2:0]  raw_addr;
   logic        mem_stall, misalign;

   dmem_access dut (
      .clk(clk), .reset(reset),
      .op_valid(op_valid), .op_read(op_read), .op_write(op_write),
      .op_addr(op_addr), .op_wdata(op_wdata), .op_msize(op_msize),
      .advance(advance), .flush(flush),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
      .dresp_data(dresp_data),
      .raw_data(raw_data), .raw_addr(raw_addr),
      .mem_stall(mem_stall), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_raw;
   logic [2:0]  exp_raddr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-by-byte view of the access.
   function automatic int nbytes(input msize_t s);
      return 1 << int'(s);
   endfunction

   function automatic logic [7:0] ref_strobe(input logic wr, input msize_t s, input int a);
      logic [7:0] r = '0;
      for (int b = 0; b < 8; b++)
         if (wr && b >= a && b < a + nbytes(s)) r[b] = 1'b1;
      return r;
   endfunction

   function automatic logic [63:0] ref_data(input logic [63:0] w, input int a);
      logic [63:0] r = '0;
      for (int b = 0; b < 8; b++)
         if (b >= a) r[8*b +: 8] = w[8*(b-a) +: 8];
      return r;
   endfunction

   function automatic logic ref_mis(input logic rd, input logic wr, input msize_t s, input int a);
      return (rd | wr) && ((a % nbytes(s)) != 0);
   endfunction

   typedef struct {
      logic        rd;
      logic        wr;
      msize_t      sz;
      logic [2:0]  a;
      logic [63:0] wd;
      logic [7:0]  es;
      logic [63:0] ed;
      logic        em;
   } vec_t;
   vec_t tbl[11];

   task automatic idle_inputs();
      op_valid = 0; op_read = 0; op_write = 0; op_addr = '0; op_wdata = '0;
      op_msize = MSIZE1; advance = 0; flush = 0;
      dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
   endtask

   task automatic do_access(input logic rd, input logic wr, input msize_t sz,
                            input logic [63:0] addr, input logic [63:0] wd, input int lat,
                            input logic [63:0] rdata, input int flush_at, input int hold,
                            input logic exit_by_flush);
      logic [7:0]  es = ref_strobe(wr, sz, int'(addr[2:0]));
      logic [63:0] ed = ref_data(wd, int'(addr[2:0]));
      bit killed = (flush_at >= 0) && (flush_at < lat);
      @(negedge clk);
      op_valid = 1; op_read = rd; op_write = wr; op_msize = sz; op_addr = addr; op_wdata = wd;
      flush = 0; advance = 0; dresp_data_ok = 0; dresp_addr_ok = 0; dresp_data = rdata;
      #1;
      chk("start_stall", mem_stall, 1);
      chk("start_dreq_valid", dreq_valid, 0);
      chk("start_misalign", misalign, 0);
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         dresp_data_ok = (k == lat);
         dresp_addr_ok = (k == ((lat == 0) ? 0 : 1));
         flush = (k == flush_at);
         #1;
         chk("req_valid", dreq_valid, 1);
         chk("req_stall", mem_stall, 1);
         chk("req_addr", dreq_addr, addr);
         chk("req_size", 64'(dreq_size), 64'(sz));
         chk("req_strobe", dreq_strobe, es);
         chk("req_data", dreq_data, ed);
      end
      if (!killed) begin
         exp_raw   = rdata;
         exp_raddr = addr[2:0];
      end
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         dresp_data_ok = 0; dresp_addr_ok = 0; op_valid = 0;
         advance = (h == hold) && !exit_by_flush;
         flush   = (h == hold) && exit_by_flush;
         #1;
         chk("post_valid", dreq_valid, 0);
         chk("post_stall", mem_stall, 0);
         chk("post_raw_data", raw_data, exp_raw);
         chk("post_raw_addr", 64'(raw_addr), 64'(exp_raddr));
      end
      @(negedge clk);
      advance = 0; flush = 0;
   endtask

   task automatic do_misalign(input logic rd, input logic wr, input msize_t sz,
                              input logic [63:0] addr, input logic [63:0] wd);
      @(negedge clk);
      op_valid = 1; op_read = rd; op_write = wr; op_msize = sz; op_addr = addr; op_wdata = wd;
      flush = 0; advance = 0;
      #1;
      chk("mis_flag", misalign, 1);
      chk("mis_stall", mem_stall, 0);
      chk("mis_valid", dreq_valid, 0);
      @(negedge clk);
      #1;
      chk("mis_valid_hold", dreq_valid, 0);
      chk("mis_stall_hold", mem_stall, 0);
      op_valid = 0;
   endtask

   initial begin
      tbl[0]  = '{0, 1, MSIZE1, 3'd3, 64'h5A,               8'h08, 64'h0000_0000_5A00_0000, 0};
      tbl[1]  = '{0, 1, MSIZE2, 3'd6, 64'hBEEF,             8'hC0, 64'hBEEF_0000_0000_0000, 0};
      tbl[2]  = '{0, 1, MSIZE2, 3'd5, 64'hBEEF,             8'h60, 64'h00BE_EF00_0000_0000, 1};
      tbl[3]  = '{0, 1, MSIZE4, 3'd4, 64'h1122_3344,        8'hF0, 64'h1122_3344_0000_0000, 0};
      tbl[4]  = '{0, 1, MSIZE4, 3'd2, 64'h1122_3344,        8'h3C, 64'h0000_1122_3344_0000, 1};
      tbl[5]  = '{0, 1, MSIZE8, 3'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 0};
      tbl[6]  = '{1, 0, MSIZE8, 3'd4, 64'hFFFF,             8'h00, 64'h0000_FFFF_0000_0000, 1};
      tbl[7]  = '{1, 0, MSIZE1, 3'd7, 64'hAB,               8'h00, 64'hAB00_0000_0000_0000, 0};
      tbl[8]  = '{1, 0, MSIZE4, 3'd4, 64'h0,                8'h00, 64'h0,                    0};
      tbl[9]  = '{0, 0, MSIZE8, 3'd1, 64'h1,                8'h00, 64'h0000_0000_0000_0100, 0};
      tbl[10] = '{0, 1, MSIZE1, 3'd0, 64'hFFFF_FFFF_FFFF_FF12, 8'h01, 64'hFFFF_FFFF_FFFF_FF12, 0};

      idle_inputs();
      reset = 1;
      exp_raw = '0; exp_raddr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      chk("rst_valid", dreq_valid, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_raw_data", raw_data, 0);
      chk("rst_raw_addr", 64'(raw_addr), 0);

      // Lane formatting; flush holds the FSM in IDLE meanwhile.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         op_valid = 1; op_read = tbl[i].rd; op_write = tbl[i].wr; op_msize = tbl[i].sz;
         op_addr = 64'h8000_0000_0000_1000 | 64'(tbl[i].a); op_wdata = tbl[i].wd; flush = 1;
         #1;
         chk($sformatf("tbl%0d_strobe", i), dreq_strobe, tbl[i].es);
         chk($sformatf("tbl%0d_data", i), dreq_data, tbl[i].ed);
         chk($sformatf("tbl%0d_misalign", i), misalign, tbl[i].em);
         chk($sformatf("tbl%0d_stall", i), mem_stall, 0);
         chk($sformatf("tbl%0d_valid", i), dreq_valid, 0);
      end
      @(negedge clk);
      idle_inputs();

      // Zero-wait LW at ..04
      do_access(1, 0, MSIZE4, 64'h0000_0040_0000_1004, 64'h0, 0, 64'hAABB_CCDD_1122_3344, -1, 0, 0);
      chk("lw_raw_addr", 64'(raw_addr), 64'h4);
      // SB at ..03
      do_access(0, 1, MSIZE1, 64'h0000_0040_0000_2003, 64'h5A, 1, 64'h0, -1, 1, 0);
      // addr_ok at +1, data_ok at +3
      do_access(1, 0, MSIZE8, 64'h0000_0040_0000_3008, 64'h0, 3, 64'h1357_9BDF_2468_ACE0, -1, 0, 0);
      // Misaligned LD
      do_misalign(1, 0, MSIZE8, 64'h0000_0040_0000_4004, 64'h0);
      // Flush one cycle into a 3-cycle load: result dropped, flush exits DONE path unused
      do_access(1, 0, MSIZE4, 64'h0000_0040_0000_5000, 64'h0, 3, 64'hDEAD_BEEF_DEAD_BEEF, 1, 0, 0);
      // Flush while in DONE
      do_access(0, 1, MSIZE2, 64'h0000_0040_0000_6002, 64'h77AA, 2, 64'h0F0F_0F0F_0F0F_0F0F, -1, 1, 1);

      for (int n = 0; n < 40; n++) begin
         logic        rd = 1'($urandom_range(0, 1));
         msize_t      sz = msize_t'($urandom_range(0, 3));
         logic [63:0] addr = {$urandom, $urandom};
         logic [63:0] wd = {$urandom, $urandom};
         logic [63:0] rdat = {$urandom, $urandom};
         int          lat = $urandom_range(0, 3);
         int          fa = -1;
         if (lat > 0 && $urandom_range(0, 3) == 0) fa = $urandom_range(0, lat - 1);
         if ($urandom_range(0, 1) == 1) addr[2:0] = addr[2:0] & ~3'(nbytes(sz) - 1);
         if (ref_mis(rd, ~rd, sz, int'(addr[2:0])))
            do_misalign(rd, ~rd, sz, addr, wd);
         else
            do_access(rd, ~rd, sz, addr, wd, lat, rdat, fa, $urandom_range(0, 1),
                      1'($urandom_range(0, 1)));
      end

      // Reset while in REQ
      @(negedge clk);
      op_valid = 1; op_read = 1; op_write = 0; op_msize = MSIZE8;
      op_addr = 64'h0000_0040_0000_7000; flush = 0; advance = 0; dresp_data_ok = 0;
      @(negedge clk);
      #1;
      chk("rstreq_valid_before", dreq_valid, 1);
      @(negedge clk);
      reset = 1; op_valid = 0;
      @(negedge clk);
      reset = 0;
      #1;
      chk("rstreq_valid", dreq_valid, 0);
      chk("rstreq_stall", mem_stall, 0);
      chk("rstreq_raw_data", raw_data, 0);
      chk("rstreq_raw_addr", 64'(raw_addr), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
